// File: rtl/seg_scan.sv
// Time-multiplexed scan driver for an 8-digit seven-segment display.
// Selects one digit per slot and snapshots display data once per frame.
module seg_scan #(
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned NUM_DIGITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] data,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  blank,
  output logic [7:0]  digit_en,
  output logic [3:0]  hex_out,
  output logic        dp_out,
  output logic        frame_done
);

  localparam int unsigned      CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCAN_DIV - 1);
  localparam logic [2:0]       LAST_IDX = 3'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [31:0]      shadow_data;
  logic [7:0]       shadow_dp;
  logic [7:0]       shadow_blank;
  logic [7:0]       slot_mask;

  logic        tick;
  logic        wrap;
  logic [2:0]  idx_next;
  logic [31:0] src_data;
  logic [7:0]  src_dp;
  logic [7:0]  src_blank;
  logic [7:0]  mask_next;

  // On a frame wrap the digit-0 slot reads the live inputs, which are being
  // latched into the shadow registers on that same edge.
  always_comb begin
    tick      = (cnt == CNT_MAX);
    wrap      = tick && (idx == LAST_IDX);
    idx_next  = wrap ? 3'd0 : idx + 3'd1;
    src_data  = wrap ? data  : shadow_data;
    src_dp    = wrap ? dp_in : shadow_dp;
    src_blank = wrap ? blank : shadow_blank;
    mask_next = src_blank[idx_next] ? 8'h00 : (8'h01 << idx_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      idx          <= LAST_IDX;
      shadow_data  <= 32'h0;
      shadow_dp    <= 8'h00;
      shadow_blank <= 8'h00;
      slot_mask    <= 8'h00;
      digit_en     <= 8'h00;
      hex_out      <= 4'h0;
      dp_out       <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + CNT_W'(1);
      frame_done <= wrap;
      if (tick) begin
        idx       <= idx_next;
        slot_mask <= mask_next;
        hex_out   <= src_data[{idx_next, 2'b00} +: 4];
        dp_out    <= src_dp[idx_next];
      end
      if (wrap) begin
        shadow_data  <= data;
        shadow_dp    <= dp_in;
        shadow_blank <= blank;
      end
      // en gates every cycle; slot_mask remembers the ungated selection.
      digit_en <= en ? (tick ? mask_next : slot_mask) : 8'h00;
    end
  end

endmodule
